// File: rtl/msdap_mem_pkg.sv
// msdap_mem_pkg: shared word-memory constants and loader FSM state type
package msdap_mem_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 1024;
  localparam int CNT_W     = $clog2(MEM_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT, DONE} loader_state_t;
endpackage

// File: rtl/serial_mem_loader_sipo.sv
// sipo_word: MSB-first serial-to-parallel word shifter with bit counter
module sipo_word #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);
  localparam int BC_W = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] sr_q;
  logic [BC_W-1:0]   cnt_q;
  // clr together with shift_en restarts the count on the bit being shifted in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (shift_en) sr_q <= {sr_q[DATA_W-2:0], din};
      cnt_q <= clr ? BC_W'(shift_en) : (shift_en ? cnt_q + BC_W'(1) : cnt_q);
    end
  end
  assign word       = sr_q;
  assign word_valid = (cnt_q == BC_W'(DATA_W));
endmodule

// File: rtl/serial_mem_loader.sv
// serial_mem_loader: deserialises framed serial words and writes a block into word memory
module serial_mem_loader #(
  parameter int DATA_W     = msdap_mem_pkg::DATA_W,
  parameter int ADDR_W     = msdap_mem_pkg::ADDR_W,
  parameter int BASE_ADDR  = 0,
  parameter int LOAD_WORDS = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sdata_in,
  input  logic              frame,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);
  import msdap_mem_pkg::*;

  if (LOAD_WORDS < 1 || BASE_ADDR < 0 || BASE_ADDR + LOAD_WORDS > MEM_DEPTH || DATA_W < 2)
  begin : g_bad_params
    $error("serial_mem_loader: illegal BASE_ADDR/LOAD_WORDS/DATA_W combination");
  end

  loader_state_t     state_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              mem_we_q, busy_q, done_q, frame_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] word;
  logic              word_valid, wr, last, new_msb, mid_err, shift_en, clr;

  // start overrides everything in its cycle, including a coincident frame
  always_comb begin
    wr       = !start && state_q == SHIFT && word_valid;
    last     = wr && word_cnt_q == CNT_W'(LOAD_WORDS - 1);
    mid_err  = !start && frame && state_q == SHIFT && !word_valid;
    new_msb  = !start && frame && (state_q == WAIT_FRAME || (state_q == SHIFT && !last));
    shift_en = new_msb || (!start && state_q == SHIFT && !word_valid);
    clr      = start || new_msb || wr;
  end

  sipo_word #(.DATA_W(DATA_W)) u_sipo (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .shift_en   (shift_en),
    .din        (sdata_in),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(BASE_ADDR);
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mem_we_q <= wr;
      if (wr) begin
        mem_addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
        mem_wdata_q <= word;
        word_cnt_q  <= word_cnt_q + CNT_W'(1);
      end
      if (start) begin
        state_q     <= WAIT_FRAME;
        word_cnt_q  <= '0;
        frame_err_q <= 1'b0;
        done_q      <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          WAIT_FRAME: if (frame) state_q <= SHIFT;
          SHIFT: begin
            if (mid_err) frame_err_q <= 1'b1;
            else if (last) state_q <= DONE;
            else if (wr) state_q <= frame ? SHIFT : WAIT_FRAME;
          end
          DONE: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_mem_loader.sv
// tb_serial_mem_loader: directed vector bench for the serial memory loader (3-word block at 0x10)
module tb_serial_mem_loader;
  logic        clk = 1'b0;
  logic        reset_n, start, sdata_in, frame;
  logic        mem_we, busy, done, frame_err;
  logic [15:0] mem_addr, mem_wdata;
  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  int          got_c[$];
  logic        prev_we = 1'b0;

  typedef struct {
    bit          go;
    int          gap;
    logic [15:0] data;
    logic [15:0] addr;
    bit          last;
  } vec_t;
  vec_t tv[6];

  serial_mem_loader #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'h10), .LOAD_WORDS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sdata_in(sdata_in), .frame(frame),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
      got_c.push_back(cyc);
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_consecutive got mem_we high twice in a row exp single-cycle strobe");
      end
    end
    prev_we = mem_we;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sdata_in = 1'($urandom);
      frame    = 1'b0;
      tick();
    end
  endtask

  task automatic send(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      sdata_in = w[i];
      frame    = (i == 15);
      tick();
    end
    frame = 1'b0;
  endtask

  task automatic expw(input logic [15:0] a, input logic [15:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic go();
    start = 1'b1;
    frame = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", frame_err, 0);
  endtask

  task automatic finish_load(input string tag);
    tick();
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_done_n1"}, done, 0);
    tick();
    chk({tag, "_done_n2"}, done, 1);
    chk({tag, "_busy_n2"}, busy, 0);
  endtask

  initial begin
    tv[0] = '{1, 3, 16'hA5C3, 16'h10, 0};
    tv[1] = '{0, 2, 16'h0001, 16'h11, 0};
    tv[2] = '{0, 5, 16'hFFFF, 16'h12, 1};
    tv[3] = '{1, 0, 16'h1234, 16'h10, 0};
    tv[4] = '{0, 0, 16'h8000, 16'h11, 0};
    tv[5] = '{0, 0, 16'h7FFE, 16'h12, 1};

    reset_n = 1'b0; start = 1'b0; sdata_in = 1'b0; frame = 1'b0;
    repeat (3) tick();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 16'h10);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", frame_err, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      sdata_in = 1'($urandom);
      frame    = (i % 8 == 0);
      tick();
    end
    frame = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    for (int i = 0; i < 6; i++) begin
      if (tv[i].go) go();
      idle(tv[i].gap);
      send(tv[i].data, 16);
      expw(tv[i].addr, tv[i].data);
      if (tv[i].last) finish_load($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      sdata_in = 1'($urandom);
      frame    = (i % 16 == 0);
      tick();
    end
    frame = 1'b0;
    chk("done_hold", done, 1);
    chk("done_busy", busy, 0);

    go();
    send(16'hDEAD, 7);
    send(16'h5A5A, 16);
    expw(16'h10, 16'h5A5A);
    chk("ferr_set", frame_err, 1);
    idle(2);
    send(16'h0F0F, 16);
    expw(16'h11, 16'h0F0F);
    idle(1);
    send(16'h3C3C, 16);
    expw(16'h12, 16'h3C3C);
    finish_load("ferr");
    chk("ferr_sticky", frame_err, 1);

    go();
    send(16'h1111, 16);
    expw(16'h10, 16'h1111);
    send(16'h2222, 16);
    expw(16'h11, 16'h2222);
    send(16'h3333, 5);
    start = 1'b1; frame = 1'b1; sdata_in = 1'b1;
    tick();
    start = 1'b0; frame = 1'b0;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    idle(3);
    send(16'h4444, 16);
    expw(16'h10, 16'h4444);
    send(16'h5555, 16);
    expw(16'h11, 16'h5555);
    idle(4);
    send(16'h6666, 16);
    expw(16'h12, 16'h6666);
    finish_load("abort");
    chk("abort_err", frame_err, 0);

    go();
    send(16'hABCD, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 16'h10);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      sdata_in = 1'(16'hABCD >> i);
      frame    = 1'b0;
      tick();
    end
    idle(4);
    chk("arst_after_busy", busy, 0);
    chk("arst_after_we", mem_we, 0);

    chk("n_writes", got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), got_a[i], exp_a[i]);
      chk($sformatf("wr%0d_data", i), got_d[i], exp_d[i]);
    end
    if (got_c.size() >= 6) begin
      chk("b2b_gap1", got_c[4] - got_c[3], 16);
      chk("b2b_gap2", got_c[5] - got_c[4], 16);
    end else begin
      errors++;
      $display("FAIL b2b_writes got %0d writes exp at least 6", got_c.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
